// File: rtl/mod_gen_pkg.sv
// Shared definitions for the bias-modulation generator: FSM encoding,
// mode constants and the signed add with saturate/wrap used for level+offset.
package mod_gen_pkg;

  // RUN states carry the output state index in bits [1:0]; IDLE reads as index 0.
  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_IDLE = 3'd4
  } mod_state_e;

  localparam logic MODE_2STATE = 1'b0;
  localparam logic MODE_4STATE = 1'b1;

  // Internal arithmetic width; any OUTPUT_BIT up to 62 fits with headroom.
  localparam int ADD_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [ADD_W-1:0] val;
  } add_res_t;

  // Adds two already sign-extended operands and returns the result folded into
  // a w-bit signed range: clamped (flagging sat) or wrapped modulo 2^w.
  function automatic add_res_t add_sat(input logic signed [ADD_W-1:0] a,
                                       input logic signed [ADD_W-1:0] b,
                                       input int                      w,
                                       input bit                      sat_en);
    logic signed [ADD_W-1:0] sum;
    logic signed [ADD_W-1:0] max_v;
    logic signed [ADD_W-1:0] min_v;
    add_res_t                r;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = sum;
    if (sat_en) begin
      if (sum > max_v) begin
        r.val = max_v;
        r.sat = 1'b1;
      end else if (sum < min_v) begin
        r.val = min_v;
        r.sat = 1'b1;
      end
    end else begin
      r.val = (sum <<< (ADD_W - w)) >>> (ADD_W - w);
    end
    return r;
  endfunction

endpackage

// File: rtl/modulation_gen_v5_step_trig.sv
// Decimating step-trigger counter: fires on the first state entry after a
// clear and then on every (reload+1)-th entry. The pulse is registered so it
// lines up with the generator's state register.
module mod_step_trig #(
  parameter int CNT_BIT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               entry_i,
  input  logic [CNT_BIT-1:0] reload_i,
  output logic               pulse_o
);

  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;

  // Count state entries; a zero count fires and reloads, otherwise count down.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (entry_i) begin
      if (cnt_q == '0) begin
        pulse_d = 1'b1;
        cnt_d   = reload_i;
      end else begin
        cnt_d = cnt_q - CNT_BIT'(1);
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/modulation_gen_v5.sv
// Square/staircase bias-modulation generator (2-state or 4-state) with
// programmable dwell, per-channel offset and decimated step trigger.
// Configuration is captured into shadow registers only when a period starts.
// Build option: MODULATION_GEN_SAT_EN clamps level+offset and drives o_sat;
// without it the sum wraps and o_sat is 0.
// Handshake: none; i_en is a level enable sampled every clock, and all outputs
// are registered together with the state register.
module modulation_gen_v5
  import mod_gen_pkg::*;
#(
  parameter int OUTPUT_BIT = 16,
  parameter int CNT_BIT    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_mode,
  input  logic        [CNT_BIT-1:0]    i_freq_cnt,
  input  logic signed [OUTPUT_BIT-1:0] i_amp_0,
  input  logic signed [OUTPUT_BIT-1:0] i_amp_1,
  input  logic signed [OUTPUT_BIT-1:0] i_amp_2,
  input  logic signed [OUTPUT_BIT-1:0] i_amp_3,
  input  logic signed [OUTPUT_BIT-1:0] i_offset,
  input  logic        [CNT_BIT-1:0]    i_ramp_trig_cnt,
  output logic signed [OUTPUT_BIT-1:0] o_mod_out,
  output logic        [1:0]            o_state,
  output logic                         o_status,
  output logic                         o_stepTrig,
  output logic                         o_period_start,
  output logic                         o_sat
);

`ifdef MODULATION_GEN_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  mod_state_e state_q, state_d;
  logic [CNT_BIT-1:0] dwell_q, dwell_d;

  // Shadow configuration, only replaced at a period start.
  logic                             sh_mode_q, sh_mode_d;
  logic [CNT_BIT-1:0]               sh_freq_q, sh_freq_d;
  logic [3:0][OUTPUT_BIT-1:0]       sh_amp_q, sh_amp_d;
  logic [OUTPUT_BIT-1:0]            sh_off_q, sh_off_d;
  logic [CNT_BIT-1:0]               sh_ramp_q, sh_ramp_d;

  logic [OUTPUT_BIT-1:0] mod_q, mod_d;
  logic                  ps_q, ps_d;
  logic                  sat_d;

  logic       entry;
  logic       load;
  logic       idle_d;
  mod_state_e last_st;
  logic signed [OUTPUT_BIT-1:0] level_d;
  logic signed [OUTPUT_BIT-1:0] off_s_d;
  add_res_t   sum_res;
  logic       unused_sum_bits;

  assign last_st = (sh_mode_q == MODE_4STATE) ? ST_S3 : ST_S1;

  // Next state, dwell count and shadow capture.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    sh_mode_d = sh_mode_q;
    sh_freq_d = sh_freq_q;
    sh_amp_d  = sh_amp_q;
    sh_off_d  = sh_off_q;
    sh_ramp_d = sh_ramp_q;
    entry     = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_S0;
          entry   = 1'b1;
          load    = 1'b1;
        end
      end
      ST_S0, ST_S1, ST_S2, ST_S3: begin
        if (!i_en) begin
          // Disable wins over any boundary; the period is abandoned.
          state_d = ST_IDLE;
          dwell_d = '0;
        end else if (dwell_q == '0) begin
          entry = 1'b1;
          if (state_q == last_st) begin
            state_d = ST_S0;
            load    = 1'b1;
          end else begin
            state_d = mod_state_e'(state_q + 3'd1);
          end
        end else begin
          dwell_d = dwell_q - CNT_BIT'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dwell_d = '0;
      end
    endcase
    if (load) begin
      sh_mode_d = i_mode;
      sh_freq_d = i_freq_cnt;
      sh_amp_d  = {i_amp_3, i_amp_2, i_amp_1, i_amp_0};
      sh_off_d  = i_offset;
      sh_ramp_d = i_ramp_trig_cnt;
    end
    // Freshly loaded shadows govern the dwell of the state being entered.
    if (entry) begin
      dwell_d = sh_freq_d;
    end
  end

  // Output values for the state being entered, computed from next-state
  // shadows so outputs and state register change on the same edge.
  always_comb begin
    idle_d  = (state_d == ST_IDLE);
    level_d = $signed(sh_amp_d[state_d[1:0]]);
    off_s_d = $signed(sh_off_d);
    sum_res = add_sat(ADD_W'(level_d), ADD_W'(off_s_d), OUTPUT_BIT, SatEn);
    mod_d   = '0;
    sat_d   = 1'b0;
    if (!idle_d) begin
      mod_d = sum_res.val[OUTPUT_BIT-1:0];
      sat_d = sum_res.sat;
    end
    ps_d = entry && (state_d == ST_S0);
  end

  assign unused_sum_bits = ^{sum_res.val[ADD_W-1:OUTPUT_BIT], sum_res.sat};

  // State, dwell, shadow and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      dwell_q   <= '0;
      sh_mode_q <= 1'b0;
      sh_freq_q <= '0;
      sh_amp_q  <= '0;
      sh_off_q  <= '0;
      sh_ramp_q <= '0;
      mod_q     <= '0;
      ps_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      sh_mode_q <= sh_mode_d;
      sh_freq_q <= sh_freq_d;
      sh_amp_q  <= sh_amp_d;
      sh_off_q  <= sh_off_d;
      sh_ramp_q <= sh_ramp_d;
      mod_q     <= mod_d;
      ps_q      <= ps_d;
    end
  end

`ifdef MODULATION_GEN_SAT_EN
  logic sat_q;

  // Saturation flag registered alongside the modulation output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign o_sat = sat_q;
`else
  logic unused_sat_d;
  assign unused_sat_d = sat_d;
  assign o_sat        = 1'b0;
`endif

  mod_step_trig #(
    .CNT_BIT (CNT_BIT)
  ) u_step_trig (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear_i  (idle_d),
    .entry_i  (entry),
    .reload_i (sh_ramp_d),
    .pulse_o  (o_stepTrig)
  );

  assign o_mod_out      = mod_q;
  assign o_state        = state_q[1:0];
  assign o_status       = state_q[0];
  assign o_period_start = ps_q;

endmodule
